banked_burst_mem: RTL

Parametrised, multi-bank, single-port word memory for the near-memory CNN datapath. It replaces the tristate shared-bus memory with separate request, write-data and read-data channels using valid/ready handshakes. It adds incrementing burst transfers, byte strobes and read backpressure. It sits between the accelerator's layer controller and the feature-map/weight storage.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_bank.sv | 42 ++++
 rtl/banked_burst_mem.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the banked burst memory.
package mem_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Bank count of the default build and its select width.
  localparam int NUM_BANKS_DEFAULT = 4;
  localparam int BANK_SEL_WIDTH    = $clog2(NUM_BANKS_DEFAULT);

  // Select width for an arbitrary bank count (never zero so vectors stay legal).
  function automatic int bank_sel_width(input int num_banks);
    if (num_banks > 1) begin
      return $clog2(num_banks);
    end else begin
      return 1;
    end
  endfunction

  // Strobe merge for one byte lane: keep the stored byte unless enabled.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    if (en) begin
      return new_byte;
    end else begin
      return old_byte;
    end
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One interleaved bank: synchronous single-port RAM, per-byte write enable,
// registered read output that only changes when a read is enabled.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [ROW_WIDTH-1:0]    row,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int DEPTH = 2 ** ROW_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array: merge strobed bytes into the addressed word (not reset).
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        mem[row][8*i +: 8] <= merge_byte(mem[row][8*i +: 8], wdata[8*i +: 8], strb[i]);
      end
    end
  end

  // Read register: holds its value between read enables so stalls are stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[row];
    end
  end

endmodule

// File: rtl/banked_burst_mem.sv
// Multi-bank word memory with valid/ready request, write and read channels,
// incrementing bursts, byte strobes and read backpressure.
module banked_burst_mem
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_BANKS     = 4,
  parameter int BURST_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_w_en,
  input  logic [ADDRESS_WIDTH-1:0]  req_address,
  input  logic [BURST_WIDTH-1:0]    req_len,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [DATA_WIDTH-1:0]     w_data,
  input  logic [DATA_WIDTH/8-1:0]   w_strb,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [DATA_WIDTH-1:0]     r_data,
  output logic                      r_last,
  output logic                      busy
);

  localparam int SEL_W   = bank_sel_width(NUM_BANKS);
  localparam int ROW_RAW = ADDRESS_WIDTH - $clog2(NUM_BANKS);
  localparam int ROW_W   = (ROW_RAW > 0) ? ROW_RAW : 1;
  localparam int CNT_W   = BURST_WIDTH + 1;

  state_t                    state, next_state;
  logic [ADDRESS_WIDTH-1:0]  addr;
  logic [CNT_W-1:0]          remaining;
  logic [SEL_W-1:0]          sel;
  logic [SEL_W-1:0]          bank_idx;
  logic [ROW_W-1:0]          row;
  logic                      wr_fire;
  logic                      rd_issue;
  logic                      rd_done;
  logic [DATA_WIDTH-1:0]     bank_rdata [NUM_BANKS];

  // Low address bits pick the bank, the rest pick the row inside it.
  assign bank_idx = SEL_W'(int'(addr) % NUM_BANKS);
  assign row      = ROW_W'(int'(addr) / NUM_BANKS);

  assign req_ready = (state == IDLE);
  assign w_ready   = (state == WRITE);
  assign busy      = (state != IDLE);
  assign r_data    = bank_rdata[sel];

  // Beat qualifiers and next-state decode.
  always_comb begin
    next_state = state;
    wr_fire    = 1'b0;
    rd_issue   = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = req_w_en ? WRITE : READ;
        end else begin
          next_state = IDLE;
        end
      end
      WRITE: begin
        wr_fire = w_valid;
        if (w_valid && (remaining == CNT_W'(1))) begin
          next_state = IDLE;
        end else begin
          next_state = WRITE;
        end
      end
      READ: begin
        rd_issue = (remaining != CNT_W'(0)) && (!r_valid || r_ready);
        rd_done  = r_valid && r_ready && r_last;
        if (rd_done) begin
          next_state = IDLE;
        end else begin
          next_state = READ;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Burst address/count: latched on request, stepped on every write beat or read issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if ((state == IDLE) && req_valid) begin
      addr      <= req_address;
      remaining <= {1'b0, req_len} + CNT_W'(1);
    end else if (wr_fire || rd_issue) begin
      addr      <= addr + ADDRESS_WIDTH'(1);
      remaining <= remaining - CNT_W'(1);
    end
  end

  // Read channel: a new beat appears on issue; a handshake without issue empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      sel     <= '0;
    end else if (rd_issue) begin
      r_valid <= 1'b1;
      r_last  <= (remaining == CNT_W'(1));
      sel     <= bank_idx;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_WIDTH  (ROW_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_fire && (bank_idx == SEL_W'(b))),
      .re    (rd_issue && (bank_idx == SEL_W'(b))),
      .strb  (w_strb),
      .row   (row),
      .wdata (w_data),
      .rdata (bank_rdata[b])
    );
  end

endmodule
